// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide issue controller: unit function codes,
// EX-stage HI/LO op codes and the controller FSM states.
package muldiv_pkg;

  localparam logic [1:0] FUNC_MULT  = 2'b00;
  localparam logic [1:0] FUNC_MULTU = 2'b01;
  localparam logic [1:0] FUNC_DIV   = 2'b10;
  localparam logic [1:0] FUNC_DIVU  = 2'b11;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  function automatic logic [1:0] op_to_func(input logic [2:0] op);
    logic [1:0] f;
    f = FUNC_MULT;
    case (op)
      OP_MULTU: f = FUNC_MULTU;
      OP_DIV:   f = FUNC_DIV;
      OP_DIVU:  f = FUNC_DIVU;
      default:  f = FUNC_MULT;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/muldiv_wait_timer.sv
// Completion detector for the WAIT phase: busy-seen flag, grace window for units
// that never raise busy, and a timeout counter that abandons a hung operation.
module muldiv_wait_timer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int BUSY_GRACE  = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_active,
  input  logic i_busy,
  output logic o_done,
  output logic o_timeout
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int GW = $clog2(BUSY_GRACE + 2);

  logic [TW-1:0] r_to_cnt;
  logic [GW-1:0] r_grace_cnt;
  logic          r_busy_seen;

  always_ff @(posedge clk) begin
    if (resetn || i_clear) begin
      r_to_cnt    <= '0;
      r_grace_cnt <= '0;
      r_busy_seen <= 1'b0;
    end else if (i_active) begin
      r_to_cnt <= r_to_cnt + TW'(1);
      // Saturate so a long wait never wraps back into the grace window
      if (r_grace_cnt < GW'(BUSY_GRACE))
        r_grace_cnt <= r_grace_cnt + GW'(1);
      if (i_busy)
        r_busy_seen <= 1'b1;
    end
  end

  assign o_done    = i_active && !i_busy &&
                     (r_busy_seen || (r_grace_cnt >= GW'(BUSY_GRACE)));
  assign o_timeout = i_active && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/muldiv_issue_ctrl.sv
// Pipeline-side initiator for the multiply/divide unit: owns HI/LO, launches
// operations with a one-cycle start pulse and stalls EX on HI/LO hazards.
module muldiv_issue_ctrl
  import muldiv_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int BUSY_GRACE  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        op_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic [1:0]  md_func,
  output logic        md_start,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        err
);
  state_t      r_state;
  logic [31:0] r_hi, r_lo, r_md_a, r_md_b, r_rd_data;
  logic [1:0]  r_md_func;
  logic        r_md_start, r_rd_valid, r_err;
  logic        w_idle, w_launch, w_wait, w_done, w_timeout, w_div_zero;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_launch   = (r_state == ST_LAUNCH);
  assign w_wait     = (r_state == ST_WAIT);
  assign w_div_zero = ((op_code == OP_DIV) || (op_code == OP_DIVU)) && (rt_val == 32'd0);

  // Every HI/LO op is accepted in IDLE; anything else stalls until the unit is free
  assign op_ready = op_valid && w_idle;

  muldiv_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .BUSY_GRACE  (BUSY_GRACE)
  ) u_wait_timer (
    .clk       (clk),
    .resetn    (resetn),
    .i_clear   (w_launch),
    .i_active  (w_wait),
    .i_busy    (md_busy),
    .o_done    (w_done),
    .o_timeout (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state    <= ST_IDLE;
      r_hi       <= '0;
      r_lo       <= '0;
      r_md_a     <= '0;
      r_md_b     <= '0;
      r_md_func  <= FUNC_MULT;
      r_rd_data  <= '0;
      r_md_start <= 1'b0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_md_start <= 1'b0;
      r_rd_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (op_ready) begin
            case (op_code)
              OP_MFHI: begin
                r_rd_data  <= r_hi;
                r_rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                r_rd_data  <= r_lo;
                r_rd_valid <= 1'b1;
              end
              OP_MTHI: r_hi <= rs_val;
              OP_MTLO: r_lo <= rs_val;
              default: begin
                if (w_div_zero) begin
                  // Divide by zero resolves locally without occupying the unit
                  r_hi <= rs_val;
                  r_lo <= 32'hFFFF_FFFF;
                end else begin
                  r_md_a     <= rs_val;
                  r_md_b     <= rt_val;
                  r_md_func  <= op_to_func(op_code);
                  r_md_start <= 1'b1;
                  r_state    <= ST_LAUNCH;
                end
              end
            endcase
          end
        end
        ST_LAUNCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (w_done) begin
            r_state <= ST_CAPTURE;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          r_hi    <= md_hi;
          r_lo    <= md_lo;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign md_func  = r_md_func;
  assign md_start = r_md_start;
  assign md_a     = r_md_a;
  assign md_b     = r_md_b;
  assign err      = r_err;

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
- Pipeline-side initiator for the multiply/divide unit `fun`.
- Accepts HI/LO-class instructions from the EX stage and launches operations on the unit with a one-cycle start pulse. Tracks the unit's busy handshake and owns the architectural HI/LO registers.
- Stalls the pipeline on HI/LO hazards and returns HI/LO read data for mfhi/mflo.

Parameters:
- TIMEOUT_CYC, 64, maximum cycles in WAIT before the operation is abandoned and the error flag set.
- BUSY_GRACE, 2, cycles after md_start within which md_busy must rise; if it never rises, busy low after the grace window still counts as done.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- resetn  in  1  synchronous, active-high reset (1 = reset).
- op_valid  in  1  EX stage presents a HI/LO instruction this cycle.
- op_code  in  3  operation: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- rs_val  in  32  operand a / write data for mthi/mtlo.
- rt_val  in  32  operand b.
- op_ready  out  1  instruction accepted this cycle; pipeline stalls while op_valid & ~op_ready.
- rd_data  out  32  HI or LO value for mfhi/mflo.
- rd_valid  out  1  rd_data valid (one-cycle pulse, same cycle as op_ready for MFHI/MFLO).
- md_func  out  2  to unit: 00 mult, 01 multu, 10 div, 11 divu.
- md_start  out  1  to unit: one-cycle launch pulse.
- md_a  out  32  to unit: operand a, held stable from LAUNCH until capture.
- md_b  out  32  to unit: operand b, held stable from LAUNCH until capture.
- md_busy  in  1  from unit.
- md_hi  in  32  from unit.
- md_lo  in  32  from unit.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (resetn=1 at a rising edge):
  - State → IDLE.
  - HI, LO, md_a, md_b, rd_data, md_func all → 0.
  - md_start, rd_valid, op_ready, err all → 0.
  - Reset mid-operation abandons the op; a later md_busy/md_hi/md_lo is ignored.
- FSM states: IDLE, LAUNCH, WAIT, CAPTURE.
- IDLE:
  - op_ready is a combinational function of op_valid/op_code, high only in IDLE.
  - MFHI/MFLO: op_ready=1; rd_data=HI/LO, rd_valid=1, both registered and visible the next cycle.
  - MTHI/MTLO: op_ready=1; HI/LO ← rs_val at the edge.
  - MULT/MULTU/DIV/DIVU:
    - Latch md_a=rs_val, md_b=rt_val and md_func, then go to LAUNCH.
    - op_ready=1 in this cycle; the instruction retires from the pipeline.
  - DIV/DIVU with rt_val==0: no launch; HI ← rs_val, LO ← 32'hFFFFFFFF; stay IDLE.
- LAUNCH:
  - md_start=1 for exactly one cycle.
  - Clear the grace and timeout counters; go to WAIT.
- WAIT:
  - Record busy_seen when md_busy=1.
  - Done when md_busy=0 and (busy_seen or grace counter ≥ BUSY_GRACE); go to CAPTURE.
  - Timeout counter increments every WAIT cycle. Reaching TIMEOUT_CYC → err=1, HI/LO unchanged, go to IDLE.
- CAPTURE: HI ← md_hi, LO ← md_lo; go to IDLE.
- Hazards:
  - Any op_valid while state≠IDLE gets op_ready=0 (stall), including MFHI/MFLO/MTHI/MTLO and new mult/div.
  - A stalled MFHI issued during CAPTURE is accepted in the following IDLE cycle and sees the new HI.
- md_start is never asserted while state≠LAUNCH.
- md_a and md_b are unchanged from LAUNCH through CAPTURE.
- Minimum mult/div occupancy is 4 cycles (IDLE accept → LAUNCH → WAIT → CAPTURE).

Decomposition:
- Package muldiv_pkg holds:
  - FUNC_MULT/MULTU/DIV/DIVU 2-bit constants.
  - OP_* 3-bit op_code constants.
  - State encodings (2-bit).
- One sub-module, muldiv_wait_timer, holds the grace counter, timeout counter and busy_seen flag. It outputs done and timeout.
- HI/LO registers and the FSM stay in the top module.

Test Plan:
- Bench pairs the block with a behavioural unit model (busy high 16 cycles after start).
- MULTU, rs=32'h7fff, rt=32'h10:
  - Exactly one md_start pulse with md_func=01.
  - After busy falls, HI=0 and LO=32'h0007fff0.
  - A following MFLO gives rd_data=32'h0007fff0.
- DIVU, rs=100, rt=7: HI=2, LO=14 after capture. A MFHI issued two cycles after the divu holds op_ready=0 until after CAPTURE, then returns 2.
- DIV, rs=32'h1234, rt=0: md_start never asserted; next-cycle MFHI=32'h1234, MFLO=32'hFFFFFFFF.
- MTHI rs=32'hA5A5A5A5, then MFHI: rd_data=32'hA5A5A5A5 with no stall; a MULT issued during a busy window stalls until IDLE.
- Model never raises busy and holds no result: capture occurs BUSY_GRACE cycles into WAIT, err stays 0. Model holds busy high forever: err=1 after TIMEOUT_CYC WAIT cycles, HI/LO unchanged, op_ready returns.
- resetn=1 for one cycle mid-WAIT: all outputs 0 next cycle; the later md_busy fall does not write HI/LO (both remain 0).
